// File: rtl/ibex_multdiv_iter_if.sv
// ibex_multdiv_iter_if: request, operand and ALU-adder signals between the execute stage and the iterative multdiv unit
interface ibex_multdiv_iter_if;
  logic        en_i;
  logic [2:0]  md_op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [33:0] alu_adder_ext_i;
  logic        alu_en_o;
  logic [32:0] alu_operand_a_o;
  logic [32:0] alu_operand_b_o;
  logic [31:0] result_o;
  logic        valid_o;
  logic        busy_o;
  modport master (
    output en_i, md_op_i, operand_a_i, operand_b_i, alu_adder_ext_i,
    input  alu_en_o, alu_operand_a_o, alu_operand_b_o, result_o, valid_o, busy_o
  );
  modport slave (
    input  en_i, md_op_i, operand_a_i, operand_b_i, alu_adder_ext_i,
    output alu_en_o, alu_operand_a_o, alu_operand_b_o, result_o, valid_o, busy_o
  );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// ibex_multdiv_iter: 34-cycle radix-2 RV32M mul/div on the shared ALU adder; clk_i, async rst_ni, md slave port carries request, ALU operands/sum, result/valid/busy
module ibex_multdiv_iter (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_multdiv_iter_if.slave md
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;
  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] hi_q, lo_q, ub_q, result_q, hi_d, lo_d, t, res_d, ua, ub;
  logic        sa_q, sb_q, sa, sb, q, div, iter, neg, unused_ext0;
  logic [63:0] prod;
  assign sa = md.operand_a_i[31] & (md.md_op_i inside {3'd1, 3'd2, 3'd4, 3'd6});
  assign sb = md.operand_b_i[31] & (md.md_op_i inside {3'd1, 3'd4, 3'd6});
  assign ua = sa ? -md.operand_a_i : md.operand_a_i;
  assign ub = sb ? -md.operand_b_i : md.operand_b_i;
  assign div = op_q[2];
  assign iter = state_q == ITER;
  assign t = {hi_q[30:0], lo_q[31]};
  assign q = hi_q[31] | md.alu_adder_ext_i[33];
  assign md.alu_en_o = iter;
  assign md.alu_operand_a_o = !iter ? '0 : div ? {t, 1'b1} : {hi_q, 1'b0};
  assign md.alu_operand_b_o = !iter ? '0 : div ? {~ub_q, 1'b1} : lo_q[0] ? {ub_q, 1'b0} : '0;
  assign hi_d = div ? (q ? md.alu_adder_ext_i[32:1] : t) : md.alu_adder_ext_i[33:2];
  assign lo_d = div ? {lo_q[30:0], q} : {md.alu_adder_ext_i[1], lo_q[31:1]};
  assign neg = sa_q ^ sb_q;
  assign prod = neg ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign res_d = op_q == 3'd0 ? prod[31:0] :
                 !div         ? prod[63:32] :
                 op_q[1]      ? (sa_q ? -hi_q : hi_q) :
                 ub_q == '0   ? '1 :
                 neg          ? -lo_q : lo_q;
  assign md.result_o = result_q;
  assign md.valid_o = state_q == DONE;
  assign md.busy_o = state_q != IDLE;
  assign unused_ext0 = md.alu_adder_ext_i[0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ub_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (md.en_i) begin
          op_q    <= md.md_op_i;
          sa_q    <= sa;
          sb_q    <= sb;
          ub_q    <= ub;
          hi_q    <= '0;
          lo_q    <= ua;
          cnt_q   <= 5'd31;
          state_q <= ITER;
        end
        ITER: if (!md.en_i) state_q <= IDLE;
        else begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: if (!md.en_i) state_q <= IDLE;
        else begin
          result_q <= res_d;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// tb_ibex_multdiv_iter: directed RV32M vectors against an arithmetic reference and a cycle-timeline model
module tb_ibex_multdiv_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  ibex_multdiv_iter_if bus();
  assign bus.alu_adder_ext_i = {1'b0, bus.alu_operand_a_o} + {1'b0, bus.alu_operand_b_o};
  ibex_multdiv_iter dut (.clk_i(clk), .rst_ni(rst_n), .md(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin p = sa / sb; return b == 0 ? 32'hFFFF_FFFF : ovf ? a : p[31:0]; end
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: begin p = sa % sb; return b == 0 ? a : ovf ? 32'h0 : p[31:0]; end
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  // timeline model: age 1..32 adder cycles, 33 final fix-up, 34 completion pulse
  int          age = 0;
  logic [31:0] exp_res = '0;
  logic [2:0]  cop = '0;
  logic [31:0] ca = '0, cb = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= 0;
      exp_res <= '0;
    end else if (age == 0) begin
      if (bus.en_i) begin
        age <= 1;
        cop <= bus.md_op_i;
        ca <= bus.operand_a_i;
        cb <= bus.operand_b_i;
      end
    end else if (age == 34) age <= 0;
    else if (!bus.en_i) age <= 0;
    else begin
      if (age == 33) exp_res <= ref_res(cop, ca, cb);
      age <= age + 1;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy_o), 64'(age != 0));
    chk("alu_en", 64'(bus.alu_en_o), 64'(age >= 1 && age <= 32));
    chk("valid", 64'(bus.valid_o), 64'(age == 34));
    chk("result", 64'(bus.result_o), 64'(exp_res));
    if (!(age >= 1 && age <= 32)) begin
      chk("alu_a_idle", 64'(bus.alu_operand_a_o), 64'd0);
      chk("alu_b_idle", 64'(bus.alu_operand_b_o), 64'd0);
    end
  end

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n, na;
    n = 0;
    na = 0;
    chk({name, "_model"}, 64'(ref_res(op, a, b)), 64'(exp));
    @(posedge clk);
    #1;
    bus.en_i = 1'b1;
    bus.md_op_i = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus.alu_en_o) na++;
    end while (!bus.valid_o && n < 40);
    chk({name, "_latency"}, 64'(n), 64'd34);
    chk({name, "_alu_cycles"}, 64'(na), 64'd32);
    chk(name, 64'(bus.result_o), 64'(exp));
    bus.en_i = 1'b0;
  endtask

  initial begin
    int nv;
    bus.en_i = 1'b0;
    bus.md_op_i = '0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_result", 64'(bus.result_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    do_op("mulh_m3_5", 3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    do_op("mulhu_2p16", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    do_op("mul_big", 3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    do_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    do_op("rem_m7_m2", 3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    do_op("div_5_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_op("rem_5_0", 3'd6, 32'd5, 32'd0, 32'd5);
    do_op("divu_7_0", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    do_op("divu_max_16", 3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    do_op("remu_max_16", 3'd7, 32'hFFFF_FFFF, 32'h10, 32'hF);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
    @(posedge clk);
    #1;
    bus.en_i = 1'b1;
    bus.md_op_i = 3'd5;
    bus.operand_a_i = 32'd1000;
    bus.operand_b_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.en_i = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(bus.busy_o), 64'd0);
    nv = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) nv++;
    end
    chk("abort_no_valid", 64'(nv), 64'd0);
    chk("abort_result", 64'(bus.result_o), 64'd2);
    do_op("divu_after_abort", 3'd5, 32'd9, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    bus.en_i = 1'b1;
    bus.md_op_i = 3'd0;
    bus.operand_a_i = 32'd11;
    bus.operand_b_i = 32'd13;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy_o), 64'd0);
    chk("arst_alu_en", 64'(bus.alu_en_o), 64'd0);
    chk("arst_valid", 64'(bus.valid_o), 64'd0);
    chk("arst_result", 64'(bus.result_o), 64'd0);
    bus.en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
